ni_inject: RTL and testbench

Network-interface packet injector between a processing element (PE) and the two virtual-channel input FIFOs of the local router port. It accepts one packet request at a time and selects a VC FIFO that reports room for a whole packet. It then serialises the packet into head, body and tail flits and writes them into that FIFO, one per cycle.

---
 rtl/ni_inject.sv | 142 ++++++++++++++
 tb/tb_ni_inject.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_inject.sv
// ni_inject -- network-interface packet injector.
//
// Sits between a processing element and the two virtual-channel input FIFOs
// of the local router port. One packet request is accepted at a time. The
// injector picks a VC whose FIFO can hold a whole packet, then writes the
// packet as head, body and tail flits into that FIFO, one flit per cycle.
//
// Ports
//   clk        : clock, rising edge
//   rst_       : asynchronous active-low reset (shared with the VC FIFOs)
//   req_valid  : PE presents a packet request
//   req_ready  : request accepted this cycle (IDLE and some VC ready)
//   req_dst    : destination node of the request
//   req_src    : source node of the request
//   ordy[1:0]  : per-VC "room for a full packet"
//   odata      : flit driven to both VC FIFOs
//   wr_en[1:0] : per-VC write strobe, one-hot or zero
//   busy       : a packet is being sent
//   pkt_id     : ID the next accepted packet will carry
//   pkt_cnt    : packets fully injected (wrapping)
module ni_inject #(
  parameter int FLITW  = 32,
  parameter int DSTW   = 4,
  parameter int IDW    = 8,
  parameter int PKTLEN = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DSTW-1:0]  req_dst,
  input  logic [DSTW-1:0]  req_src,
  input  logic [1:0]       ordy,
  output logic [FLITW-1:0] odata,
  output logic [1:0]       wr_en,
  output logic             busy,
  output logic [IDW-1:0]   pkt_id,
  output logic [15:0]      pkt_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(PKTLEN - 1);

  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_BODY = 2'b00;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  state_t          state;
  logic [DSTW-1:0] dst_q;
  logic [DSTW-1:0] src_q;
  logic [IDW-1:0]  id_q;
  logic [7:0]      idx;
  logic            vc;
  logic            last_vc;
  logic [IDW-1:0]  pkt_id_q;
  logic [15:0]     pkt_cnt_q;

  logic            sel_vc;
  logic            accept;
  logic [FLITW-1:0] flit;

  // A lone ready VC wins outright; when both are ready, alternate away from
  // the VC used last. ordy is only looked at here, at accept time -- a set
  // bit promises room for the entire packet.
  assign sel_vc    = (&ordy) ? ~last_vc : ordy[1];
  assign req_ready = (state == IDLE) && (|ordy);
  assign accept    = req_valid && req_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others; blocking here would make the result
  // depend on statement order.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      dst_q     <= '0;
      src_q     <= '0;
      id_q      <= '0;
      idx       <= '0;
      vc        <= 1'b0;
      last_vc   <= 1'b1;      // first contended pick lands on VC0
      pkt_id_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dst_q    <= req_dst;
            src_q    <= req_src;
            id_q     <= pkt_id_q;
            pkt_id_q <= pkt_id_q + 1'b1;
            vc       <= sel_vc;
            last_vc  <= sel_vc;
            idx      <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          idx <= idx + 8'd1;
          // Returning to IDLE after the tail leaves one idle cycle, so the
          // FIFO's ordy already counts the tail before the next accept.
          if (idx == LAST_IDX) begin
            state     <= IDLE;
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flit assembly for the current index; all unused bits stay zero.
  // NOTE: flit gets a full default before any branch so no path leaves it
  // unassigned -- otherwise synthesis would infer a latch.
  always_comb begin
    flit = '0;
    if (state == SEND) begin
      if (idx == 8'd0) begin
        flit[FLITW-1 -: 2]         = TYPE_HEAD;
        flit[DSTW-1:0]             = dst_q;
        flit[2*DSTW-1:DSTW]        = src_q;
        flit[2*DSTW+IDW-1:2*DSTW]  = id_q;
      end else begin
        flit[FLITW-1 -: 2]         = (idx == LAST_IDX) ? TYPE_TAIL : TYPE_BODY;
        flit[IDW-1:0]              = id_q;
        flit[IDW+7:IDW]            = idx;
      end
    end
  end

  // Outputs decode registered state only, so a reset mid-packet clears the
  // strobes immediately and no partial tail escapes.
  assign odata   = flit;
  assign wr_en   = (state == SEND) ? (vc ? 2'b10 : 2'b01) : 2'b00;
  assign busy    = (state == SEND);
  assign pkt_id  = pkt_id_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_ni_inject.sv
// Testbench for ni_inject. A packet-level reference model keeps a queue of
// the flits still owed to the FIFOs, the VC they go to, and the ID / packet
// counters; DUT outputs are compared against it every cycle.
module tb_ni_inject;

  localparam int FLITW  = 32;
  localparam int DSTW   = 4;
  localparam int IDW    = 8;
  localparam int PKTLEN = 4;

  logic             clk = 1'b0;
  logic             rst_;
  logic             req_valid;
  logic             req_ready;
  logic [DSTW-1:0]  req_dst;
  logic [DSTW-1:0]  req_src;
  logic [1:0]       ordy;
  logic [FLITW-1:0] odata;
  logic [1:0]       wr_en;
  logic             busy;
  logic [IDW-1:0]   pkt_id;
  logic [15:0]      pkt_cnt;

  ni_inject #(.FLITW(FLITW), .DSTW(DSTW), .IDW(IDW), .PKTLEN(PKTLEN)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dst   (req_dst),
    .req_src   (req_src),
    .ordy      (ordy),
    .odata     (odata),
    .wr_en     (wr_en),
    .busy      (busy),
    .pkt_id    (pkt_id),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [FLITW-1:0] m_q[$];   // flits still to be written, front = next
  int               m_vc;
  int               m_last_vc;
  logic [IDW-1:0]   m_id;
  logic [15:0]      m_cnt;

  logic [1:0]       heads[$]; // wr_en seen with each head flit
  logic [FLITW-1:0] seen[$];  // flits written, in order

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FLITW-1:0] mk_flit(input int i, input int id,
                                               input int dst, input int src);
    logic [FLITW-1:0] f;
    if (i == 0) begin
      f = (FLITW'(1) << (FLITW-2)) | (FLITW'(id) << (2*DSTW)) |
          (FLITW'(src) << DSTW) | FLITW'(dst);
    end else begin
      f = (FLITW'(i) << IDW) | FLITW'(id);
      if (i == PKTLEN-1) f = f | (FLITW'(2) << (FLITW-2));
    end
    return f;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_vc      = 0;
    m_last_vc = 1;
    m_id      = '0;
    m_cnt     = '0;
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic step();
    logic exp_rdy;
    #1;
    exp_rdy = (m_q.size() == 0) && (ordy != 2'b00);
    check("req_ready", req_ready, exp_rdy);
    // Model what the coming rising edge does.
    if (m_q.size() != 0) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_cnt = m_cnt + 16'd1;
    end else if (req_valid && ordy != 2'b00) begin
      if (ordy == 2'b01)      m_vc = 0;
      else if (ordy == 2'b10) m_vc = 1;
      else                    m_vc = (m_last_vc == 0) ? 1 : 0;
      m_last_vc = m_vc;
      for (int i = 0; i < PKTLEN; i++) m_q.push_back(mk_flit(i, m_id, req_dst, req_src));
      m_id = m_id + 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if (m_q.size() != 0) begin
      check("wr_en", wr_en, (m_vc == 1) ? 2'b10 : 2'b01);
      check("odata", odata, m_q[0]);
      check("busy", busy, 1'b1);
    end else begin
      check("wr_en_idle", wr_en, 2'b00);
      check("odata_idle", odata, '0);
      check("busy_idle", busy, 1'b0);
    end
    check("pkt_id", pkt_id, m_id);
    check("pkt_cnt", pkt_cnt, m_cnt);
    if (wr_en != 2'b00) begin
      seen.push_back(odata);
      if (odata[FLITW-1 -: 2] == 2'b01) heads.push_back(wr_en);
    end
  endtask

  task automatic do_reset();
    rst_      = 1'b0;
    req_valid = 1'b0;
    req_dst   = '0;
    req_src   = '0;
    ordy      = 2'b00;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_wr_en", wr_en, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_odata", odata, '0);
    check("rst_pkt_id", pkt_id, '0);
    check("rst_pkt_cnt", pkt_cnt, '0);
    ordy = 2'b11;
    #1;
    check("rst_req_ready_follows", req_ready, 1'b1);
    ordy = 2'b00;
    @(negedge clk);
    rst_ = 1'b1;
    heads.delete();
    seen.delete();
  endtask

  task automatic idle_cycles(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    m_reset();
    rst_ = 1'b0;
    req_valid = 1'b0;
    req_dst = '0;
    req_src = '0;
    ordy = 2'b00;

    // Reset, then a single packet dst=3 src=5 with both VCs ready.
    do_reset();
    ordy = 2'b11; req_valid = 1'b1; req_dst = 4'd3; req_src = 4'd5;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < PKTLEN; i++) step();
    check("single_head_vc", (heads.size() > 0) ? heads[0] : 2'bxx, 2'b01);
    check("single_nflits", seen.size(), PKTLEN);
    if (seen.size() == PKTLEN) begin
      check("single_f0", seen[0], 32'h4000_0053);
      check("single_f1", seen[1], 32'h0000_0100);
      check("single_f2", seen[2], 32'h0000_0200);
      check("single_f3", seen[3], 32'h8000_0300);
    end
    check("single_pkt_cnt", pkt_cnt, 16'd1);
    check("single_pkt_id", pkt_id, 8'd1);

    // Round-robin: request held for three packets, period PKTLEN+1.
    do_reset();
    ordy = 2'b11; req_valid = 1'b1; req_dst = 4'd7; req_src = 4'd2;
    for (int i = 0; i < 3*(PKTLEN+1); i++) step();
    req_valid = 1'b0;
    step();
    check("rr_npkts", heads.size(), 3);
    if (heads.size() == 3) begin
      check("rr_vc0", heads[0], 2'b01);
      check("rr_vc1", heads[1], 2'b10);
      check("rr_vc2", heads[2], 2'b01);
    end
    check("rr_pkt_cnt", pkt_cnt, 16'd3);

    // Single-VC availability: nothing ready first, then only VC1.
    do_reset();
    req_valid = 1'b1; req_dst = 4'd1; req_src = 4'd9; ordy = 2'b00;
    for (int i = 0; i < 3; i++) step();
    ordy = 2'b10;
    step();
    ordy = 2'b00;
    for (int i = 0; i < PKTLEN + 2; i++) step();
    check("vc1_head", (heads.size() > 0) ? heads[0] : 2'bxx, 2'b10);
    check("vc1_npkts", heads.size(), 1);

    // ordy drops right after accept: packet completes, next request waits.
    do_reset();
    ordy = 2'b01; req_valid = 1'b1; req_dst = 4'd4; req_src = 4'd6;
    step();
    ordy = 2'b00;
    for (int i = 0; i < PKTLEN + 3; i++) step();
    check("drop_nflits", seen.size(), PKTLEN);
    check("drop_busy", busy, 1'b0);

    // Asynchronous reset while idx = 2.
    do_reset();
    ordy = 2'b11; req_valid = 1'b1; req_dst = 4'd2; req_src = 4'd8;
    step();
    req_valid = 1'b0;
    step();
    step();                       // now showing flit index 2
    check("mid_idx2", odata[IDW+7:IDW], 8'd2);
    #2 rst_ = 1'b0;
    #1;
    check("mid_rst_wr_en", wr_en, 2'b00);
    check("mid_rst_pkt_cnt", pkt_cnt, 16'd0);
    check("mid_rst_pkt_id", pkt_id, 8'd0);
    m_reset();
    @(negedge clk);
    rst_ = 1'b1;
    idle_cycles(2);

    // Counter wrap: 256 packets back to back, then a 257th.
    do_reset();
    ordy = 2'b11; req_valid = 1'b1;
    for (int p = 0; p < 256; p++) begin
      req_dst = DSTW'($urandom);
      req_src = DSTW'($urandom);
      for (int c = 0; c < PKTLEN + 1; c++) begin
        step();
        req_valid = (p < 255) || (c < PKTLEN - 1) ? 1'b1 : 1'b0;
      end
    end
    req_valid = 1'b0;
    step();
    check("wrap_pkt_cnt", pkt_cnt, 16'd256);
    check("wrap_pkt_id", pkt_id, 8'd0);
    heads.delete();
    seen.delete();
    req_valid = 1'b1; req_dst = 4'd3; req_src = 4'd5;
    step();
    req_valid = 1'b0;
    check("wrap_head_id", odata[2*DSTW+IDW-1:2*DSTW], 8'd0);
    for (int i = 0; i < PKTLEN; i++) step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      ordy      = 2'($urandom);
      req_dst   = DSTW'($urandom);
      req_src   = DSTW'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
